// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter generator feeding a small show-ahead fetch queue.
//   Each cycle that the queue has room (or frees a slot by popping) and no
//   redirect is pending, the instruction at the current PC is enqueued
//   together with PC+4, and the PC advances by one word. A taken branch
//   (memory stage) or jump (execute stage) flushes the queue and reloads
//   the PC, with the branch taking priority over the jump.
//
// Ports
//   CLK         rising-edge clock
//   RST_N       synchronous active-low reset
//   imem_addr   instruction-memory word address, PC[IMEM_AW+1:2]
//   imem_rdata  instruction at imem_addr (asynchronous read)
//   br_valid    taken-branch redirect request
//   br_target   branch target byte address
//   jmp_valid   jump redirect request
//   jmp_target  jump target byte address
//   id_ready    decode consumes the head entry this cycle
//   id_valid    head entry is valid
//   id_instr    head-entry instruction
//   id_pc4      head-entry PC+4
//   fq_count    queue occupancy
//   misalign    sticky: an accepted redirect target was not word aligned
module pc_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     IMEM_AW  = 7,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  output logic [IMEM_AW-1:0]            imem_addr,
  input  logic [XLEN-1:0]               imem_rdata,
  input  logic                          br_valid,
  input  logic [XLEN-1:0]               br_target,
  input  logic                          jmp_valid,
  input  logic [XLEN-1:0]               jmp_target,
  input  logic                          id_ready,
  output logic                          id_valid,
  output logic [XLEN-1:0]               id_instr,
  output logic [XLEN-1:0]               id_pc4,
  output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count,
  output logic                          misalign
);

  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam logic [XLEN-1:0] WORD = XLEN'(4);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mis_q, mis_d;

  logic [XLEN-1:0] instr_mem_q [FQ_DEPTH];
  logic [XLEN-1:0] pc4_mem_q   [FQ_DEPTH];

  logic            redirect;
  logic            pop;
  logic            fetch;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] tgt_sel;

  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign pc_plus4  = pc_q + WORD;    // carry-out dropped: 2^XLEN-4 wraps to 0

  assign redirect = br_valid | jmp_valid;
  assign tgt_sel  = br_valid ? br_target : jmp_target;

  assign id_valid = (cnt_q != '0);
  assign id_instr = instr_mem_q[rptr_q];
  assign id_pc4   = pc4_mem_q[rptr_q];
  assign fq_count = cnt_q;
  assign misalign = mis_q;

  // A pop frees a slot in the same edge, so a full queue can still fetch.
  assign pop   = id_valid & id_ready & ~redirect;
  assign fetch = ~redirect & ((cnt_q < CW'(FQ_DEPTH)) | pop);

  always_comb begin
    pc_d   = pc_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    mis_d  = mis_q;
    if (redirect) begin
      pc_d   = {tgt_sel[XLEN-1:2], 2'b00};
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      mis_d  = mis_q | (tgt_sel[1:0] != 2'b00);
    end else begin
      if (fetch) begin
        pc_d   = pc_plus4;
        wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(fetch) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_q   <= RESET_PC;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      mis_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      mis_q  <= mis_d;
    end
  end

  // Queue storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge CLK) begin
    if (RST_N && fetch) begin
      instr_mem_q[wptr_q] <= imem_rdata;
      pc4_mem_q[wptr_q]   <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        CLK;
  logic        RST_N;
  logic [6:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        br_valid;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [2:0]  fq_count;
  logic        misalign;

  int n_pass;
  int n_total;

  pc_fetch_unit #(
    .XLEN(32), .IMEM_AW(7), .FQ_DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .br_valid(br_valid), .br_target(br_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .id_ready(id_ready), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc4(id_pc4),
    .fq_count(fq_count), .misalign(misalign)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory: word at address a holds 0x1000_0000 + a.
  assign imem_rdata = 32'h1000_0000 + {25'd0, imem_addr};

  // Instruction expected alongside a given PC+4 (fetched from PC = pc4-4).
  function automatic logic [31:0] exp_instr(input logic [31:0] pc4);
    logic [31:0] pc;
    pc = pc4 - 32'd4;
    return 32'h1000_0000 + {25'd0, pc[8:2]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        br;
    logic [31:0] bt;
    logic        jv;
    logic [31:0] jt;
    logic        vld;
    logic [31:0] pc4;
    logic [2:0]  cnt;
    logic [6:0]  addr;
    logic        mis;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic rst_n, input logic rdy,
                              input logic br, input logic [31:0] bt,
                              input logic jv, input logic [31:0] jt,
                              input logic vld, input logic [31:0] pc4,
                              input logic [2:0] cnt, input logic [6:0] addr,
                              input logic mis);
    vec_t v;
    v.rst_n = rst_n; v.rdy = rdy; v.br = br; v.bt = bt; v.jv = jv; v.jt = jt;
    v.vld = vld; v.pc4 = pc4; v.cnt = cnt; v.addr = addr; v.mis = mis;
    return v;
  endfunction

  task automatic drive(input logic rst_n, input logic rdy, input logic br,
                       input logic [31:0] bt, input logic jv, input logic [31:0] jt);
    RST_N = rst_n; id_ready = rdy; br_valid = br; br_target = bt;
    jmp_valid = jv; jmp_target = jt;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    RST_N = 1'b0; id_ready = 1'b0; br_valid = 1'b0; br_target = '0;
    jmp_valid = 1'b0; jmp_target = '0;

    //             rst rdy br bt            jv jt             vld pc4          cnt addr   mis
    vecs[0]  = mk(0, 1, 0, 0,            0, 0,            0, 32'h0,        0, 7'h00, 0);
    vecs[1]  = mk(0, 1, 0, 0,            0, 0,            0, 32'h0,        0, 7'h00, 0);
    vecs[2]  = mk(1, 1, 0, 0,            0, 0,            1, 32'd4,        1, 7'h01, 0);
    vecs[3]  = mk(1, 1, 0, 0,            0, 0,            1, 32'd8,        1, 7'h02, 0);
    vecs[4]  = mk(1, 1, 0, 0,            0, 0,            1, 32'd12,       1, 7'h03, 0);
    vecs[5]  = mk(1, 0, 0, 0,            0, 0,            1, 32'd12,       2, 7'h04, 0);
    vecs[6]  = mk(1, 0, 0, 0,            0, 0,            1, 32'd12,       3, 7'h05, 0);
    vecs[7]  = mk(1, 0, 0, 0,            0, 0,            1, 32'd12,       4, 7'h06, 0);
    vecs[8]  = mk(1, 0, 0, 0,            0, 0,            1, 32'd12,       4, 7'h06, 0);
    vecs[9]  = mk(1, 0, 0, 0,            0, 0,            1, 32'd12,       4, 7'h06, 0);
    vecs[10] = mk(1, 0, 0, 0,            0, 0,            1, 32'd12,       4, 7'h06, 0);
    vecs[11] = mk(1, 1, 0, 0,            0, 0,            1, 32'd16,       4, 7'h07, 0);
    vecs[12] = mk(1, 1, 0, 0,            0, 0,            1, 32'd20,       4, 7'h08, 0);
    vecs[13] = mk(1, 1, 1, 32'h40,       1, 32'h80,       0, 32'h0,        0, 7'h10, 0);
    vecs[14] = mk(1, 0, 0, 0,            0, 0,            1, 32'h44,       1, 7'h11, 0);
    vecs[15] = mk(1, 0, 0, 0,            0, 0,            1, 32'h44,       2, 7'h12, 0);
    vecs[16] = mk(1, 1, 0, 0,            1, 32'h22,       0, 32'h0,        0, 7'h08, 1);
    vecs[17] = mk(1, 1, 0, 0,            0, 0,            1, 32'h24,       1, 7'h09, 1);
    vecs[18] = mk(1, 1, 1, 32'h100,      0, 0,            0, 32'h0,        0, 7'h40, 1);
    vecs[19] = mk(1, 0, 0, 0,            0, 0,            1, 32'h104,      1, 7'h41, 1);
    vecs[20] = mk(1, 0, 0, 0,            0, 0,            1, 32'h104,      2, 7'h42, 1);
    vecs[21] = mk(0, 1, 1, 32'h200,      0, 0,            0, 32'h0,        0, 7'h00, 0);
    vecs[22] = mk(1, 1, 0, 0,            0, 0,            1, 32'd4,        1, 7'h01, 0);
    vecs[23] = mk(1, 1, 0, 0,            1, 32'hFFFF_FFFC, 0, 32'h0,       0, 7'h7F, 0);
    vecs[24] = mk(1, 1, 0, 0,            0, 0,            1, 32'h0,        1, 7'h00, 0);
    vecs[25] = mk(1, 1, 0, 0,            0, 0,            1, 32'd4,        1, 7'h01, 0);

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].rst_n, vecs[i].rdy, vecs[i].br, vecs[i].bt, vecs[i].jv, vecs[i].jt);
      check($sformatf("v%0d id_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].vld});
      check($sformatf("v%0d fq_count", i), {29'd0, fq_count}, {29'd0, vecs[i].cnt});
      check($sformatf("v%0d imem_addr", i), {25'd0, imem_addr}, {25'd0, vecs[i].addr});
      check($sformatf("v%0d misalign", i), {31'd0, misalign}, {31'd0, vecs[i].mis});
      if (vecs[i].vld) begin
        check($sformatf("v%0d id_pc4", i), id_pc4, vecs[i].pc4);
        check($sformatf("v%0d id_instr", i), id_instr, exp_instr(vecs[i].pc4));
      end
    end

    // Full queue with decode always ready: one in, one out per cycle.
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0);
    check("full fq_count", {29'd0, fq_count}, 32'd4);
    check("full head pc4", id_pc4, 32'd4);
    for (int k = 0; k < 20; k++) begin
      logic [31:0] exp_pc4;
      exp_pc4 = 32'd4 * (k + 2);
      drive(1, 1, 0, 0, 0, 0);
      check($sformatf("sb%0d fq_count", k), {29'd0, fq_count}, 32'd4);
      check($sformatf("sb%0d id_pc4", k), id_pc4, exp_pc4);
      check($sformatf("sb%0d id_instr", k), id_instr, exp_instr(exp_pc4));
    end

    // Misaligned branch wins over aligned jump; flag sticks through aligned redirects.
    drive(1, 0, 1, 32'h0000_0033, 1, 32'h0000_0080);
    check("pri addr", {25'd0, imem_addr}, 32'h0C);
    check("pri misalign", {31'd0, misalign}, 32'd1);
    drive(1, 0, 0, 0, 1, 32'h0000_0010);
    check("sticky misalign", {31'd0, misalign}, 32'd1);
    drive(1, 0, 0, 0, 0, 0);
    check("sticky pc4", id_pc4, 32'h14);
    drive(0, 0, 0, 0, 0, 0);
    check("reset clears misalign", {31'd0, misalign}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the PC and instruction width.
REQ-002 The block SHALL have parameter IMEM_AW, default 7, meaning the instruction-memory word-address width.
REQ-003 The block SHALL have parameter FQ_DEPTH, default 4 (power of two, >=2), meaning the fetch-queue entry count.
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning the PC value loaded at reset.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 CLK  in  1  rising-edge clock.
REQ-007 RST_N  in  1  synchronous active-low reset.
REQ-008 imem_addr  out  IMEM_AW  word address, = PC[IMEM_AW+1:2], combinational from PC.
REQ-009 imem_rdata  in  XLEN  instruction at imem_addr, valid in the same cycle (asynchronous memory).
REQ-010 br_valid  in  1  taken-branch redirect from the memory stage.
REQ-011 br_target  in  XLEN  branch target byte address.
REQ-012 jmp_valid  in  1  jump redirect from the execute stage.
REQ-013 jmp_target  in  XLEN  jump target byte address.
REQ-014 id_ready  in  1  decode accepts the head entry this cycle.
REQ-015 id_valid  out  1  head entry valid.
REQ-016 id_instr  out  XLEN  head-entry instruction.
REQ-017 id_pc4  out  XLEN  head-entry PC+4.
REQ-018 fq_count  out  $clog2(FQ_DEPTH+1)  queue occupancy.
REQ-019 misalign  out  1  sticky flag: an accepted redirect target had bits [1:0] != 0.

Function
REQ-020 The queue SHALL be a show-ahead FIFO: id_valid = (fq_count != 0); id_instr/id_pc4 SHALL show the oldest entry combinationally.
REQ-021 Pop SHALL occur when id_valid && id_ready && !redirect, where redirect = br_valid || jmp_valid.
REQ-022 Fetch SHALL occur when !redirect && (fq_count < FQ_DEPTH || pop); it enqueues {imem_rdata, PC+4} and sets PC <= PC+4 (modulo 2^XLEN).
REQ-023 When fetch is not possible (queue full, no pop, no redirect), PC and queue SHALL hold.
REQ-024 Redirect priority SHALL be br_valid over jmp_valid: PC <= {br_target[XLEN-1:2],2'b00} if br_valid, else {jmp_target[XLEN-1:2],2'b00}.
REQ-025 On redirect, all queue entries SHALL be discarded in the same edge (fq_count <= 0); no fetch or pop that cycle.
REQ-026 First fetch from the redirect target SHALL occur on the cycle after redirect; its entry is visible at id_* one cycle later (redirect-to-id_valid latency 2 cycles).
REQ-027 Fetch-to-visible latency SHALL be one cycle: an entry fetched at edge N is at id_* after edge N if the queue was empty.
REQ-028 Simultaneous fetch and pop SHALL leave fq_count unchanged, including at fq_count = FQ_DEPTH.
REQ-029 Read/write pointers SHALL be $clog2(FQ_DEPTH) bits and wrap naturally; fq_count SHALL never exceed FQ_DEPTH or underflow.
REQ-030 misalign SHALL set on the edge of a redirect whose selected target has [1:0] != 0, and stay set until reset.
REQ-031 PC arithmetic SHALL ignore carry-out; PC = 2^XLEN-4 fetches then wraps to 0.

Reset
REQ-032 While RST_N = 0 at a rising edge: PC <= RESET_PC, pointers and fq_count <= 0, misalign <= 0; no fetch, pop or redirect takes effect.
REQ-033 Reset SHALL override redirect, fetch and pop in the same cycle; assertion mid-operation discards all queued entries.
REQ-034 The first fetch SHALL occur at the first edge with RST_N = 1, from RESET_PC.

Verification
REQ-035 Reset release, id_ready=1, imem returns 0x1000_0000+addr -> id_valid=1 one cycle later, id_pc4 = 4, 8, 12 ... one per cycle, fq_count <= 1.
REQ-036 id_ready=0 for 6 cycles, FQ_DEPTH=4 -> fq_count saturates at 4, imem_addr holds at 4, then id_ready=1 drains entries with id_pc4 4,8,12,16 in order.
REQ-037 br_valid=1 target 0x40 and jmp_valid=1 target 0x80 same cycle with 3 entries queued -> fq_count=0 next cycle, imem_addr=0x10, id_pc4=0x44 two cycles after redirect.
REQ-038 jmp_valid=1 target 0x22 -> PC=0x20, misalign=1 and stays 1 through a later aligned redirect until RST_N=0.
REQ-039 Full queue with id_ready=1 held -> one fetch and one pop per cycle, fq_count stays 4, no entry lost or duplicated (scoreboard check).
REQ-040 RST_N=0 for one cycle with 2 entries queued and br_valid=1 -> fq_count=0, PC=RESET_PC, misalign=0, fetch resumes from RESET_PC.
